// File: rtl/rgb565_gray_ci_ctrl.sv
// rtl/rgb565_gray_ci_ctrl.sv - RGB565 to 8-bit gray custom instruction, four pixels per command
// Optional macro RGB565_GRAY_BYTESWAP_EN byte-swaps each pixel before field extraction.
module rgb565_gray_ci_ctrl #(
  parameter logic [7:0] customInstructionId = 8'd0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        ciStart,
  input  logic        ciCke,
  input  logic [7:0]  ciN,
  input  logic [31:0] ciValueA,
  input  logic [31:0] ciValueB,
  output logic        ciDone,
  output logic [31:0] ciResult
);

  typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

  state_t      state;
  logic [1:0]  cnt;
  logic [63:0] ops;
  logic [31:0] acc;

  logic [15:0] pix_raw;
  logic [15:0] pix;
  logic [7:0]  r8, g8, b8;
  logic [15:0] sum;
  logic [7:0]  gray;

  // Operand word: P0 in [15:0] up to P3 in [63:48], selected by the pixel counter.
  assign pix_raw = ops[16*cnt +: 16];

`ifdef RGB565_GRAY_BYTESWAP_EN
  assign pix = {pix_raw[7:0], pix_raw[15:8]};
`else
  assign pix = pix_raw;
`endif

  assign r8   = {pix[15:11], pix[15:13]};
  assign g8   = {pix[10:5], pix[10:9]};
  assign b8   = {pix[4:0], pix[4:2]};
  assign sum  = 16'd54 * {8'd0, r8} + 16'd183 * {8'd0, g8} + 16'd19 * {8'd0, b8};
  assign gray = 8'(sum >> 8);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= 2'd0;
      ops      <= 64'd0;
      acc      <= 32'd0;
      ciDone   <= 1'b0;
      ciResult <= 32'd0;
    end else if (ciCke) begin
      case (state)
        IDLE: begin
          ciDone   <= 1'b0;
          ciResult <= 32'd0;
          if (ciStart && (ciN == customInstructionId)) begin
            ops   <= {ciValueB, ciValueA};
            cnt   <= 2'd0;
            acc   <= 32'd0;
            state <= CONV;
          end
        end
        CONV: begin
          acc[8*cnt +: 8] <= gray;
          cnt             <= cnt + 2'd1;
          if (cnt == 2'd3) begin
            // The last byte bypasses acc so the result is valid in DONE.
            state    <= DONE;
            ciDone   <= 1'b1;
            ciResult <= {gray, acc[23:0]};
          end
        end
        DONE: begin
          ciDone   <= 1'b0;
          ciResult <= 32'd0;
          state    <= IDLE;
        end
        default: begin
          ciDone   <= 1'b0;
          ciResult <= 32'd0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rgb565_gray_ci_ctrl.sv
// tb/tb_rgb565_gray_ci_ctrl.sv - scoreboard bench for rgb565_gray_ci_ctrl
// Honours RGB565_GRAY_BYTESWAP_EN in its reference model.
module tb_rgb565_gray_ci_ctrl;

  localparam logic [7:0] ID = 8'd0;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        ciStart = 1'b0;
  logic        ciCke = 1'b1;
  logic [7:0]  ciN = 8'd0;
  logic [31:0] ciValueA = 32'd0;
  logic [31:0] ciValueB = 32'd0;
  logic        ciDone;
  logic [31:0] ciResult;

  rgb565_gray_ci_ctrl #(.customInstructionId(ID)) dut (
    .clock(clock), .reset(reset), .ciStart(ciStart), .ciCke(ciCke), .ciN(ciN),
    .ciValueA(ciValueA), .ciValueB(ciValueB), .ciDone(ciDone), .ciResult(ciResult)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] res;
    int          cyc;
  } exp_t;

  exp_t q[$];
  int   nchk = 0;
  int   nfail = 0;

  function automatic logic [7:0] gray_of(input logic [15:0] p_in);
    int p, r, g, b;
`ifdef RGB565_GRAY_BYTESWAP_EN
    p = int'({p_in[7:0], p_in[15:8]});
`else
    p = int'(p_in);
`endif
    r = p / 2048;
    g = (p / 32) % 64;
    b = p % 32;
    r = r * 8 + r / 4;
    g = g * 4 + g / 16;
    b = b * 8 + b / 4;
    return 8'((54 * r + 183 * g + 19 * b) / 256);
  endfunction

  function automatic logic [31:0] model(input logic [31:0] a, input logic [31:0] b);
    return {gray_of(b[31:16]), gray_of(b[15:0]), gray_of(a[31:16]), gray_of(a[15:0])};
  endfunction

  // Monitor: every cycle either a done pulse matching the queue head, or an idle zero bus.
  always @(negedge clock) begin
    if (!reset) begin
      if (ciDone) begin
        nchk++;
        if (q.size() == 0) begin
          nfail++;
          $display("FAIL unexpected_done cyc=%0d result=%h required no pulse", cyc, ciResult);
        end else begin
          if (ciResult !== q[0].res || cyc != q[0].cyc) begin
            nfail++;
            $display("FAIL done_check result=%h at cyc %0d, required %h at cyc %0d",
                     ciResult, cyc, q[0].res, q[0].cyc);
          end
          void'(q.pop_front());
        end
      end else begin
        nchk++;
        if (ciResult !== 32'd0) begin
          nfail++;
          $display("FAIL idle_result result=%h required 00000000 at cyc %0d", ciResult, cyc);
        end
        if (q.size() != 0 && cyc > q[0].cyc) begin
          nchk++;
          nfail++;
          $display("FAIL done_timeout no pulse by cyc %0d, required %h", q[0].cyc, q[0].res);
          void'(q.pop_front());
        end
      end
    end
  end

  // Called just after a negedge; returns one cycle after the expected DONE so the next
  // command can be accepted back-to-back.
  task automatic issue(input logic [7:0] n, input logic [31:0] a, input logic [31:0] b,
                       input int f, input bit stray);
    int c0;
    c0 = cyc;
    ciStart  = 1'b1;
    ciN      = n;
    ciValueA = a;
    ciValueB = b;
    if (n == ID) q.push_back('{res: model(a, b), cyc: c0 + 5 + f});
    @(negedge clock);
    if (stray) begin
      ciValueA = $urandom;
      ciValueB = $urandom;
    end else begin
      ciStart = 1'b0;
    end
    @(negedge clock);
    ciStart = 1'b0;
    if (f > 0) begin
      ciCke = 1'b0;
      repeat (f) @(negedge clock);
      ciCke = 1'b1;
    end
    while (cyc < c0 + 6 + f) @(negedge clock);
  endtask

  task automatic check_reset_outputs(input string name);
    nchk++;
    if (ciDone !== 1'b0 || ciResult !== 32'd0) begin
      nfail++;
      $display("FAIL %s done=%b result=%h required 0/00000000", name, ciDone, ciResult);
    end
  endtask

  initial begin
    logic [7:0] n;
    #1 check_reset_outputs("power_on_reset");
    @(negedge clock);
    @(negedge clock);
    check_reset_outputs("reset_held");
    reset = 1'b0;
    @(negedge clock);

    issue(8'd0, 32'hF800FFFF, 32'h001F07E0, 0, 1'b0);
    issue(8'd5, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 1'b0);
    repeat (20) @(negedge clock);
    issue(8'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 3, 1'b0);
    issue(8'd0, 32'h12345678, 32'h9ABCDEF0, 0, 1'b1);
    issue(8'd0, 32'h000000F8, 32'h00000000, 0, 1'b0);
    issue(8'd0, 32'h0000FFFF, 32'h00000000, 1, 1'b1);

    // Abort a command mid-conversion; no pulse may follow.
    ciStart  = 1'b1;
    ciN      = ID;
    ciValueA = $urandom;
    ciValueB = $urandom;
    @(negedge clock);
    ciStart = 1'b0;
    @(negedge clock);
    #2 reset = 1'b1;
    #1 check_reset_outputs("mid_conv_reset");
    @(negedge clock);
    check_reset_outputs("mid_conv_reset_held");
    reset = 1'b0;
    @(negedge clock);
    issue(8'd0, 32'h0000FFFF, 32'h00000000, 0, 1'b0);

    for (int i = 0; i < 40; i++) begin
      n = ($urandom_range(0, 4) == 0) ? 8'($urandom_range(1, 255)) : ID;
      issue(n, $urandom, $urandom, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 2)) @(negedge clock);
    end

    repeat (12) @(negedge clock);
    nchk++;
    if (q.size() != 0) begin
      nfail++;
      $display("FAIL pending_at_end %0d entries outstanding, required 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", nchk, nfail);
    $finish;
  end

endmodule

// File: doc/rgb565_gray_ci_ctrl.md
RGB565_GRAY_CI_CTRL -- requirements
Module: rgb565_gray_ci_ctrl

Interface
REQ-001 SHALL have parameter customInstructionId, default 8'd0: custom-instruction number this block answers to.
REQ-002 SHALL have port clock  input  1  single system clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port ciStart  input  1  instruction start strobe from CPU.
REQ-005 SHALL have port ciCke  input  1  clock enable; low freezes all state.
REQ-006 SHALL have port ciN  input  8  custom-instruction number presented with ciStart.
REQ-007 SHALL have port ciValueA  input  32  pixels P0 = [15:0] and P1 = [31:16].
REQ-008 SHALL have port ciValueB  input  32  pixels P2 = [15:0] and P3 = [31:16].
REQ-009 SHALL have port ciDone  output  1  one-cycle completion pulse.
REQ-010 SHALL have port ciResult  output  32  packed gray bytes; zero whenever ciDone is low, so it can be OR-combined on the CI bus.

Function
REQ-011 SHALL accept a command only when ciStart=1, ciCke=1, ciN==customInstructionId and state==IDLE; it then latches ciValueA/ciValueB into operand registers.
REQ-012 SHALL implement FSM IDLE -> CONV -> DONE -> IDLE, with a 2-bit pixel counter cleared on accept.
REQ-013 In CONV, SHALL convert exactly one pixel per enabled cycle through a single shared converter, in order P0, P1, P2, P3, writing gray(Pk) into result byte k ([8k+7:8k]).
REQ-014 SHALL leave CONV for DONE after counter value 3 is processed; the counter wraps 3->0 without other effect.
REQ-015 Converter: r5=[15:11], g6=[10:5], b5=[4:0]; expand R8={r5,r5[4:2]}, G8={g6,g6[5:4]}, B8={b5,b5[4:2]}; gray=(54*R8+183*G8+19*B8)>>8, with a 16-bit unsigned intermediate and no rounding (max 255).
REQ-016 In DONE, SHALL drive ciDone=1 and ciResult=packed bytes for exactly one cycle, then return to IDLE; ciResult=0 in every other state.
REQ-017 Latency: accept at edge T -> ciDone high during cycle T+5 (4 CONV cycles plus 1 DONE cycle), with ciCke held high.
REQ-018 With ciCke=0, SHALL hold state, counter, operands and partial result; ciDone/ciResult keep their current values.
REQ-019 SHALL ignore ciStart in CONV and DONE, including a matching ciN; no re-latch, no second pulse.
REQ-020 SHALL never respond to ciStart with ciN!=customInstructionId; ciDone stays 0.
REQ-021 Back-to-back: a valid ciStart in the cycle after DONE (state IDLE) SHALL be accepted normally.

Reset
REQ-022 Reset SHALL be asynchronous and active-high, and SHALL force state=IDLE, counter=0, operands=0, partial result=0, ciDone=0, ciResult=0.
REQ-023 Reset asserted mid-CONV or in DONE SHALL abort the command with no ciDone pulse; the first accept after deassertion behaves as from power-up.

Configuration
REQ-024 Macro RGB565_GRAY_BYTESWAP_EN: when defined, each 16-bit pixel SHALL be byte-swapped ({[7:0],[15:8]}) before field extraction, for big-endian camera data.
REQ-025 When RGB565_GRAY_BYTESWAP_EN is not defined, pixels SHALL be used as presented; no swap logic is synthesized.

Verification
REQ-026 ciN=0, A=0xF800FFFF, B=0x001F07E0, ciStart 1 cycle -> ciDone 1 cycle at T+5 with ciResult=0x12B635FF.
REQ-027 ciN=5 (ID 0), A=B=0xFFFFFFFF -> ciDone stays 0 and ciResult stays 0 for 20 cycles.
REQ-028 Valid start with A=B=0xFFFFFFFF, ciCke low for 3 cycles during CONV -> ciDone at T+8 with ciResult=0xFFFFFFFF.
REQ-029 Reset pulsed at T+2 of a command; new command A=0x0000FFFF, B=0 after release -> only one ciDone, with ciResult=0x000000FF.
REQ-030 Second valid ciStart at T+2 with different operands -> ignored; single ciDone at T+5 carrying the first command's result.
REQ-031 With RGB565_GRAY_BYTESWAP_EN defined, A=0x000000F8, B=0 -> ciResult=0x00000035 (P0 decoded as pure red).
